clk_div_ctrl: RTL

- Programmable clock-divider sequencer.
- Generates a glitch-free divided clock (div_clk) and a one-cycle period-boundary strobe (div_tick) from the system clock.
- Accepts divisor updates through a valid/ready handshake and applies them only at period boundaries.
- Supports graceful start/stop. Sits between the register/config interface and the divider flop chain, sequencing when the divider runs and with which ratio.

---
 rtl/clk_div_pkg.sv | 17 +
 rtl/clk_div_counter.sv | 52 +++++
 rtl/clk_div_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clk_div_ctrl divider sequencer.
// Optional status outputs are enabled with CLK_DIV_STATUS_EN (see clk_div_ctrl.sv).
package clk_div_pkg;

    typedef enum logic {
        OFF = 1'b0,
        RUN = 1'b1
    } state_e;

    localparam int MIN_DIV = 2;

    // Works on a 32-bit value so any CNT_W up to 32 can cast the result back down.
    function automatic logic [31:0] half_ceil(input logic [31:0] n);
        return (n >> 1) + {31'd0, n[0]};
    endfunction

endpackage

// File: rtl/clk_div_counter.sv
// Period counter with registered div_clk/div_tick.
// Outputs are computed from the next-cycle count and divisor.
module clk_div_counter
    import clk_div_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             active_i,
    input  logic             run_nxt_i,
    input  logic [CNT_W-1:0] n_cur_i,
    input  logic [CNT_W-1:0] n_nxt_i,
    output logic             wrap_o,
    output logic             div_clk_o,
    output logic             div_tick_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_clk_q, div_clk_d;
    logic             tick_q, tick_d;

    assign wrap_o = active_i && (cnt_q == n_cur_i - CNT_W'(1));

    always_comb begin
        cnt_d = '0;
        if (run_nxt_i && active_i && !wrap_o)
            cnt_d = cnt_q + CNT_W'(1);
        // Evaluated against the divisor that will be active next cycle,
        // so a boundary reload shapes the new period from its first cycle.
        div_clk_d = run_nxt_i && (cnt_d < CNT_W'(half_ceil(32'(n_nxt_i))));
        tick_d    = run_nxt_i && (cnt_d == n_nxt_i - CNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            cnt_q     <= '0;
            div_clk_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_clk_q <= div_clk_d;
            tick_q    <= tick_d;
        end
    end

    assign div_clk_o  = div_clk_q;
    assign div_tick_o = tick_q;
    assign cnt_o      = cnt_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock-divider sequencer: run/stop FSM, divisor handshake, boundary reload.
// Define CLK_DIV_STATUS_EN to add cur_div/phase status outputs.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int DIV_RST = 2
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             div_clk,
    output logic             div_tick,
    output logic             busy,
`ifdef CLK_DIV_STATUS_EN
    output logic [CNT_W-1:0] cur_div,
    output logic [CNT_W-1:0] phase,
`endif
    output logic             cfg_err
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] pdiv_q, pdiv_d;
    logic             pend_q, pend_d;
    logic             err_q, err_d;
    logic             run_nxt, wrap, xfer, legal;
    logic [CNT_W-1:0] cnt;

    assign xfer  = cfg_valid && cfg_ready;
    assign legal = cfg_div >= CNT_W'(MIN_DIV);

    always_ff @(posedge clk) begin
        if (!clear_n) state_q <= OFF;
        else          state_q <= state_d;
    end

    // en is only looked at in OFF or on the boundary cycle of RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            OFF:     if (en) state_d = RUN;
            RUN:     if (wrap && !en) state_d = OFF;
            default: state_d = OFF;
        endcase
    end

    always_comb begin
        busy      = (state_q == RUN);
        cfg_ready = !pend_q;
        run_nxt   = (state_d == RUN);
    end

    always_comb begin
        n_d    = n_q;
        pend_d = pend_q;
        pdiv_d = pdiv_q;
        err_d  = xfer && !legal;
        if (state_q == RUN) begin
            if (wrap && pend_q) begin
                n_d    = pdiv_q;
                pend_d = 1'b0;
            end
            if (xfer && legal) begin
                pend_d = 1'b1;
                pdiv_d = cfg_div;
            end
        end else if (xfer && legal) begin
            n_d = cfg_div;
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            n_q    <= CNT_W'(DIV_RST);
            pdiv_q <= '0;
            pend_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            n_q    <= n_d;
            pdiv_q <= pdiv_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    clk_div_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk        (clk),
        .clear_n    (clear_n),
        .active_i   (busy),
        .run_nxt_i  (run_nxt),
        .n_cur_i    (n_q),
        .n_nxt_i    (n_d),
        .wrap_o     (wrap),
        .div_clk_o  (div_clk),
        .div_tick_o (div_tick),
        .cnt_o      (cnt)
    );

    assign cfg_err = err_q;

`ifdef CLK_DIV_STATUS_EN
    assign cur_div = n_q;
    assign phase   = cnt;
`else
    logic unused_cnt;
    assign unused_cnt = ^cnt;
`endif

endmodule
